// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - decode plus ID/EX/MEM/WB control pipeline with load-use and branch-flush handling
module pipe_ctrl_unit #(
    parameter int INST_W  = 16,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    input  logic [INST_W-1:0]  inst,
    input  logic               stall_ext,
    input  logic               br_taken,
    output logic               id_ready,
    output logic               id_out_en,
    output logic               ex_lr_en,
    output logic               ex_brx,
    output logic [3:0]         ex_alu_sel,
    output logic [1:0]         ex_br_sel,
    output logic               mem_wr_en,
    output logic               mem_imm_sel,
    output logic               wb_wb_sel,
    output logic               wb_data_sel,
    output logic               wb_reg_en,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [3:0]         opcode;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;

    assign opcode = inst[INST_W-1 -: 4];
    assign rd     = inst[INST_W-5 -: RADDR_W];
    assign rs1    = inst[INST_W-5-RADDR_W -: RADDR_W];
    assign rs2    = inst[INST_W-5-2*RADDR_W -: RADDR_W];

    logic       d_lr_en;
    logic       d_brx;
    logic [3:0] d_alu_sel;
    logic [1:0] d_br_sel;
    logic       d_wr_en;
    logic       d_imm_sel;
    logic       d_wb_sel;
    logic       d_reg_en;
    logic       d_out_en;
    logic       d_uses_rs;

    // Opcode decode into per-stage control fields; anything unlisted stays 0
    always_comb begin
        d_lr_en   = 1'b0;
        d_brx     = 1'b0;
        d_alu_sel = 4'd0;
        d_br_sel  = 2'b00;
        d_wr_en   = 1'b0;
        d_imm_sel = 1'b0;
        d_wb_sel  = 1'b0;
        d_reg_en  = 1'b0;
        d_out_en  = 1'b0;
        d_uses_rs = 1'b0;
        case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                d_alu_sel = opcode;
                d_reg_en  = 1'b1;
                d_uses_rs = 1'b1;
            end
            4'h6: begin
                d_out_en  = 1'b1;
                d_alu_sel = 4'd6;
                d_uses_rs = 1'b1;
            end
            4'h7: begin
                d_alu_sel = 4'd7;
                d_reg_en  = 1'b1;
            end
            4'h8: begin
                d_alu_sel = 4'd8;
                d_uses_rs = 1'b1;
            end
            4'h9: d_br_sel = 2'b01;
            4'hA: begin
                d_br_sel = 2'b10;
                d_brx    = inst[INST_W-5];
            end
            4'hB: begin
                d_br_sel = 2'b01;
                d_lr_en  = 1'b1;
            end
            4'hC: d_br_sel = 2'b11;
            4'hD: begin
                d_wb_sel = 1'b1;
                d_reg_en = 1'b1;
            end
            4'hE: begin
                d_alu_sel = 4'd9;
                d_wr_en   = 1'b1;
                d_uses_rs = 1'b1;
            end
            4'hF: begin
                d_imm_sel = 1'b1;
                d_reg_en  = 1'b1;
            end
            default: d_alu_sel = 4'd0;
        endcase
    end

    // EX-stage copies of fields that later stages still need
    logic ex_wr_en;
    logic ex_imm_sel;
    logic ex_wb_sel;
    logic ex_reg_en;
    logic mem_wb_sel;
    logic mem_reg_en;
    logic hazard;
    logic load_ex;

    // Only a LOAD sets wb_sel, so ex_wb_sel marks a valid LOAD sitting in EX
    assign hazard    = ex_wb_sel & inst_valid & d_uses_rs & ((ex_rd == rs1) | (ex_rd == rs2));
    assign id_ready  = ~stall_ext & (~hazard | br_taken);
    assign id_out_en = d_out_en & inst_valid & id_ready;
    assign load_ex   = inst_valid & ~hazard & ~br_taken;
    assign wb_data_sel = 1'b0;

    // EX stage register: take the decoded instruction or a bubble, hold on stall_ext
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_lr_en   <= 1'b0;
            ex_brx     <= 1'b0;
            ex_alu_sel <= 4'd0;
            ex_br_sel  <= 2'b00;
            ex_wr_en   <= 1'b0;
            ex_imm_sel <= 1'b0;
            ex_wb_sel  <= 1'b0;
            ex_reg_en  <= 1'b0;
            ex_rd      <= '0;
        end else if (!stall_ext) begin
            ex_lr_en   <= load_ex & d_lr_en;
            ex_brx     <= load_ex & d_brx;
            ex_alu_sel <= load_ex ? d_alu_sel : 4'd0;
            ex_br_sel  <= load_ex ? d_br_sel : 2'b00;
            ex_wr_en   <= load_ex & d_wr_en;
            ex_imm_sel <= load_ex & d_imm_sel;
            ex_wb_sel  <= load_ex & d_wb_sel;
            ex_reg_en  <= load_ex & d_reg_en;
            ex_rd      <= load_ex ? rd : '0;
        end
    end

    // MEM and WB stage registers simply shift forward when not externally stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_imm_sel <= 1'b0;
            mem_wb_sel  <= 1'b0;
            mem_reg_en  <= 1'b0;
            wb_wb_sel   <= 1'b0;
            wb_reg_en   <= 1'b0;
        end else if (!stall_ext) begin
            mem_wr_en   <= ex_wr_en;
            mem_imm_sel <= ex_imm_sel;
            mem_wb_sel  <= ex_wb_sel;
            mem_reg_en  <= ex_reg_en;
            wb_wb_sel   <= mem_wb_sel;
            wb_reg_en   <= mem_reg_en;
        end
    end

    // Saturating event counters; a taken branch wins over a coincident hazard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!stall_ext) begin
            if (br_taken) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else if (hazard) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit against an instruction-level pipeline model
module tb_pipe_ctrl_unit;

    localparam int IW = 16;
    localparam int RW = 4;

    logic          clk;
    logic          rst_n;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic          stall_ext;
    logic          br_taken;

    logic          id_ready, id_out_en, ex_lr_en, ex_brx, mem_wr_en, mem_imm_sel;
    logic          wb_wb_sel, wb_data_sel, wb_reg_en;
    logic [3:0]    ex_alu_sel;
    logic [1:0]    ex_br_sel;
    logic [RW-1:0] ex_rd;
    logic [15:0]   stall_cnt, flush_cnt;

    logic          id_ready_s, id_out_en_s, ex_lr_en_s, ex_brx_s, mem_wr_en_s, mem_imm_sel_s;
    logic          wb_wb_sel_s, wb_data_sel_s, wb_reg_en_s;
    logic [3:0]    ex_alu_sel_s;
    logic [1:0]    ex_br_sel_s;
    logic [RW-1:0] ex_rd_s;
    logic [1:0]    stall_cnt_s, flush_cnt_s;

    pipe_ctrl_unit #(.INST_W(IW), .RADDR_W(RW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
        .stall_ext(stall_ext), .br_taken(br_taken), .id_ready(id_ready),
        .id_out_en(id_out_en), .ex_lr_en(ex_lr_en), .ex_brx(ex_brx),
        .ex_alu_sel(ex_alu_sel), .ex_br_sel(ex_br_sel), .mem_wr_en(mem_wr_en),
        .mem_imm_sel(mem_imm_sel), .wb_wb_sel(wb_wb_sel), .wb_data_sel(wb_data_sel),
        .wb_reg_en(wb_reg_en), .ex_rd(ex_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl_unit #(.INST_W(IW), .RADDR_W(RW), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
        .stall_ext(stall_ext), .br_taken(br_taken), .id_ready(id_ready_s),
        .id_out_en(id_out_en_s), .ex_lr_en(ex_lr_en_s), .ex_brx(ex_brx_s),
        .ex_alu_sel(ex_alu_sel_s), .ex_br_sel(ex_br_sel_s), .mem_wr_en(mem_wr_en_s),
        .mem_imm_sel(mem_imm_sel_s), .wb_wb_sel(wb_wb_sel_s), .wb_data_sel(wb_data_sel_s),
        .wb_reg_en(wb_reg_en_s), .ex_rd(ex_rd_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       lr;
        logic       brx;
        logic [3:0] alu;
        logic [1:0] br;
        logic       wr;
        logic       imm;
        logic       wbs;
        logic       reg_en;
        logic       out_en;
    } ctl_t;

    // Model: each stage holds a whole instruction word; a bubble is the all-zero NOP
    logic [IW-1:0] m_ex, m_mem, m_wb;
    int            m_stall, m_flush, m_stall_s, m_flush_s;
    logic          last_ready;
    int            n_assert = 0;
    int            n_fail   = 0;

    function automatic ctl_t dec(input logic [IW-1:0] w);
        ctl_t c;
        logic [3:0] op;
        c  = '0;
        op = w[15:12];
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin c.alu = op; c.reg_en = 1'b1; end
            4'h6: begin c.out_en = 1'b1; c.alu = 4'd6; end
            4'h7: begin c.alu = 4'd7; c.reg_en = 1'b1; end
            4'h8: c.alu = 4'd8;
            4'h9: c.br = 2'b01;
            4'hA: begin c.br = 2'b10; c.brx = w[11]; end
            4'hB: begin c.br = 2'b01; c.lr = 1'b1; end
            4'hC: c.br = 2'b11;
            4'hD: begin c.wbs = 1'b1; c.reg_en = 1'b1; end
            4'hE: begin c.alu = 4'd9; c.wr = 1'b1; end
            4'hF: begin c.imm = 1'b1; c.reg_en = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic reads_regs(input logic [3:0] op);
        return (op >= 4'h1 && op <= 4'h6) || op == 4'h8 || op == 4'hE;
    endfunction

    function automatic logic load_use(input logic iv, input logic [IW-1:0] w);
        return m_ex[15:12] == 4'hD && iv && reads_regs(w[15:12]) &&
               (m_ex[11:8] == w[7:4] || m_ex[11:8] == w[3:0]);
    endfunction

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] d,
                                         input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ctl_t ce, cm, cw, ci;
        logic rdy;
        ce  = dec(m_ex);
        cm  = dec(m_mem);
        cw  = dec(m_wb);
        ci  = dec(inst);
        rdy = !stall_ext && (!load_use(inst_valid, inst) || br_taken);
        last_ready = rdy;
        chk("id_ready",    32'(id_ready),    32'(rdy));
        chk("id_out_en",   32'(id_out_en),   32'(ci.out_en && inst_valid && rdy));
        chk("ex_lr_en",    32'(ex_lr_en),    32'(ce.lr));
        chk("ex_brx",      32'(ex_brx),      32'(ce.brx));
        chk("ex_alu_sel",  32'(ex_alu_sel),  32'(ce.alu));
        chk("ex_br_sel",   32'(ex_br_sel),   32'(ce.br));
        chk("ex_rd",       32'(ex_rd),       32'(m_ex[11:8]));
        chk("mem_wr_en",   32'(mem_wr_en),   32'(cm.wr));
        chk("mem_imm_sel", 32'(mem_imm_sel), 32'(cm.imm));
        chk("wb_wb_sel",   32'(wb_wb_sel),   32'(cw.wbs));
        chk("wb_data_sel", 32'(wb_data_sel), 32'(0));
        chk("wb_reg_en",   32'(wb_reg_en),   32'(cw.reg_en));
        chk("stall_cnt",   32'(stall_cnt),   32'(m_stall));
        chk("flush_cnt",   32'(flush_cnt),   32'(m_flush));
        chk("s_id_ready",  32'(id_ready_s),  32'(rdy));
        chk("s_ex_alu",    32'(ex_alu_sel_s), 32'(ce.alu));
        chk("s_mem_wr_en", 32'(mem_wr_en_s), 32'(cm.wr));
        chk("s_wb_reg_en", 32'(wb_reg_en_s), 32'(cw.reg_en));
        chk("s_stall_cnt", 32'(stall_cnt_s), 32'(m_stall_s));
        chk("s_flush_cnt", 32'(flush_cnt_s), 32'(m_flush_s));
    endtask

    // One clock: apply inputs, check, then advance the model at the edge
    task automatic cycle(input logic iv, input logic [IW-1:0] w, input logic st, input logic br);
        logic hzv;
        inst_valid = iv;
        inst       = w;
        stall_ext  = st;
        br_taken   = br;
        #1;
        check_all();
        hzv = load_use(iv, w);
        @(posedge clk);
        if (!st) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (iv && !hzv && !br) ? w : '0;
            if (br) begin
                if (m_flush < 65535) m_flush++;
                if (m_flush_s < 3) m_flush_s++;
            end else if (hzv) begin
                if (m_stall < 65535) m_stall++;
                if (m_stall_s < 3) m_stall_s++;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0;
        m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    endtask

    // Assert reset between clock edges and confirm outputs clear without a clock
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    logic [IW-1:0] cur;
    logic          cur_iv, cur_st, cur_br;

    initial begin
        rst_n = 1'b0;
        inst_valid = 1'b0;
        inst = '0;
        stall_ext = 1'b0;
        br_taken = 1'b0;
        model_reset();
        last_ready = 1'b1;
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD then SUB
        cycle(1'b1, mk(4'h1, 4'd1, 4'd2, 4'd3), 1'b0, 1'b0);
        chk("add_in_ex", 32'(ex_alu_sel), 32'(1));
        cycle(1'b1, mk(4'h2, 4'd2, 4'd1, 4'd1), 1'b0, 1'b0);
        chk("sub_in_ex", 32'(ex_alu_sel), 32'(2));
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("add_wb_reg_en", 32'(wb_reg_en), 32'(1));
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("sub_wb_reg_en", 32'(wb_reg_en), 32'(1));

        // LOAD r3 then ADD using r3
        cycle(1'b1, mk(4'hD, 4'd3, 4'd0, 4'd0), 1'b0, 1'b0);
        cycle(1'b1, mk(4'h1, 4'd1, 4'd3, 4'd2), 1'b0, 1'b0);
        chk("lu_bubble", 32'(ex_alu_sel), 32'(0));
        chk("lu_stall_cnt", 32'(stall_cnt), 32'(1));
        cycle(1'b1, mk(4'h1, 4'd1, 4'd3, 4'd2), 1'b0, 1'b0);
        chk("lu_add_late", 32'(ex_alu_sel), 32'(1));

        // BR.Z with the condition bit set, then a flushed ADD
        cycle(1'b1, mk(4'hA, 4'd8, 4'd0, 4'd0), 1'b0, 1'b0);
        chk("brz_brx", 32'(ex_brx), 32'(1));
        chk("brz_br_sel", 32'(ex_br_sel), 32'(2));
        cycle(1'b1, mk(4'h1, 4'd1, 4'd2, 4'd3), 1'b0, 1'b1);
        chk("flush_no_add", 32'(ex_alu_sel), 32'(0));
        chk("flush_cnt_1", 32'(flush_cnt), 32'(1));
        cycle(1'b0, '0, 1'b0, 1'b0);

        // STORE held in EX for three stalled cycles
        cycle(1'b1, mk(4'hE, 4'd0, 4'd5, 4'd6), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, mk(4'h2, 4'd1, 4'd1, 4'd1), 1'b1, 1'b1);
            chk("stall_store_held", 32'(ex_alu_sel), 32'(9));
        end
        cycle(1'b1, mk(4'h2, 4'd1, 4'd1, 4'd1), 1'b0, 1'b1);
        chk("store_mem_wr_en", 32'(mem_wr_en), 32'(1));
        chk("br_after_stall", 32'(flush_cnt), 32'(2));

        // Hazard and taken branch together
        cycle(1'b1, mk(4'hD, 4'd5, 4'd0, 4'd0), 1'b0, 1'b0);
        cycle(1'b1, mk(4'h3, 4'd1, 4'd0, 4'd5), 1'b0, 1'b1);
        chk("both_flush", 32'(flush_cnt), 32'(3));
        chk("both_stall", 32'(stall_cnt), 32'(1));

        // Five more hazards: the 2-bit counter pins at 3
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, mk(4'hD, 4'd3, 4'd0, 4'd0), 1'b0, 1'b0);
            cycle(1'b1, mk(4'h8, 4'd0, 4'd3, 4'd0), 1'b0, 1'b0);
            cycle(1'b1, mk(4'h8, 4'd0, 4'd3, 4'd0), 1'b0, 1'b0);
        end
        chk("sat_small", 32'(stall_cnt_s), 32'(3));
        chk("sat_big", 32'(stall_cnt), 32'(6));

        async_reset();
        chk("rst_stall", 32'(stall_cnt), 32'(0));

        // Randomized traffic; a held instruction is re-presented until consumed
        cur = '0; cur_iv = 1'b0; cur_st = 1'b0; cur_br = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) async_reset();
            if (!(cur_iv && !last_ready)) begin
                cur = mk(4'($urandom_range(15, 0)), 4'($urandom_range(3, 0)),
                         4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)));
                cur_iv = ($urandom_range(99, 0) < 85);
            end
            if (!(cur_st && cur_br)) cur_br = ($urandom_range(99, 0) < 15);
            cur_st = ($urandom_range(99, 0) < 12);
            cycle(cur_iv, cur, cur_st, cur_br);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
